// File: rtl/video_sync_gen.sv
// Composite-sync generator for NTSC/PAL interlaced video, built on a half-line slot grid.
// Build macro LINE_TRI_EN adds the tri_line input and the line_tri one-shot output.
module video_sync_gen #(
  parameter int HALF_NTSC = 429,
  parameter int HALF_PAL  = 432,
  parameter int HS_W      = 64,
  parameter int EQ_W      = 32,
  parameter int SER_W     = 64
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       en,
  input  logic       video_mode,
  output logic       hs_out,
  output logic       odd_field_tri,
  output logic       field_out,
  output logic       vs_out,
  output logic [9:0] pulse_cnt
`ifdef LINE_TRI_EN
  ,
  input  logic [9:0] tri_line,
  output logic       line_tri
`endif
);

  localparam logic [9:0] HALF_N = 10'(HALF_NTSC);
  localparam logic [9:0] HALF_P = 10'(HALF_PAL);
  localparam logic [9:0] HS_W10 = 10'(HS_W);
  localparam logic [9:0] EQ_W10 = 10'(EQ_W);
  localparam logic [9:0] SER_W10 = 10'(SER_W);

  logic [9:0] pc;
  logic [9:0] sc;
  logic       fld;
  logic       mode_r;

  logic [9:0] half;
  logic [9:0] ns;
  logic [9:0] vi;
  logic [9:0] broad_lo;
  logic [9:0] broad_hi;
  logic       in_vblank;
  logic       is_broad;
  logic       has_pulse;
  logic       low;
  logic       fall;
  logic       frame_start;
  logic       pc_last;
  logic       sc_last;
  logic [9:0] cnt_nxt;

  always_comb begin
    half     = mode_r ? HALF_P : HALF_N;
    ns       = mode_r ? 10'd625 : 10'd525;
    vi       = mode_r ? 10'd15 : 10'd18;
    broad_lo = mode_r ? 10'd5 : 10'd6;
    broad_hi = mode_r ? 10'd10 : 10'd12;
    in_vblank = sc < vi;
    is_broad  = (sc >= broad_lo) && (sc < broad_hi);
    // Active slots alternate; the field bit picks the parity, giving the half-line offset.
    has_pulse = in_vblank || ((sc[0] ^ vi[0]) == fld);
    low = 1'b0;
    if (in_vblank) begin
      low = is_broad ? (pc < (half - SER_W10)) : (pc < EQ_W10);
    end else if (has_pulse) begin
      low = pc < HS_W10;
    end
    fall        = has_pulse && (pc == '0);
    frame_start = !fld && (sc == '0) && (pc == '0);
    cnt_nxt     = frame_start ? 10'd1 : pulse_cnt + 10'd1;
    pc_last     = pc == (half - 10'd1);
    sc_last     = sc == (ns - 10'd1);
  end

  always_ff @(posedge clk_in) begin
    if (rst || !en) begin
      pc            <= '0;
      sc            <= '0;
      fld           <= 1'b0;
      mode_r        <= video_mode;
      hs_out        <= 1'b1;
      odd_field_tri <= 1'b0;
      vs_out        <= 1'b0;
      field_out     <= 1'b0;
      pulse_cnt     <= '0;
    end else begin
      hs_out        <= ~low;
      odd_field_tri <= frame_start;
      vs_out        <= is_broad;
      field_out     <= fld;
      if (fall) pulse_cnt <= cnt_nxt;
      if (pc_last) begin
        pc <= '0;
        if (sc_last) begin
          sc  <= '0;
          fld <= ~fld;
          // Mode only changes on a frame boundary (even field wrapping to odd).
          if (fld) mode_r <= video_mode;
        end else begin
          sc <= sc + 10'd1;
        end
      end else begin
        pc <= pc + 10'd1;
      end
    end
  end

`ifdef LINE_TRI_EN
  logic [9:0] tri_r;

  always_ff @(posedge clk_in) begin
    if (rst || !en) begin
      tri_r    <= tri_line;
      line_tri <= 1'b0;
    end else begin
      line_tri <= fall && (tri_r != '0) && (cnt_nxt == tri_r);
      if (pc_last && sc_last && fld) tri_r <= tri_line;
    end
  end
`endif

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: per-cycle scoreboard fed by a frame-time reference model,
// plus whole-frame falling-edge totals. Timing parameters are scaled down to keep runs short.
module tb_video_sync_gen;

  localparam int T_HALF_N = 13;
  localparam int T_HALF_P = 16;
  localparam int T_HS_W   = 4;
  localparam int T_EQ_W   = 2;
  localparam int T_SER_W  = 3;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       video_mode = 1'b0;
  logic [9:0] tri_line = 10'd20;
  logic       hs_out;
  logic       odd_field_tri;
  logic       field_out;
  logic       vs_out;
  logic [9:0] pulse_cnt;
  logic       lt_act;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // {hs, odd_field_tri, vs, field, pulse_cnt[9:0], line_tri}
  logic [14:0] exp_q[$];

  video_sync_gen #(
    .HALF_NTSC(T_HALF_N),
    .HALF_PAL (T_HALF_P),
    .HS_W     (T_HS_W),
    .EQ_W     (T_EQ_W),
    .SER_W    (T_SER_W)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .en           (en),
    .video_mode   (video_mode),
    .hs_out       (hs_out),
    .odd_field_tri(odd_field_tri),
    .field_out    (field_out),
    .vs_out       (vs_out),
    .pulse_cnt    (pulse_cnt)
`ifdef LINE_TRI_EN
    ,
    .tri_line     (tri_line),
    .line_tri     (lt_act)
`endif
  );

`ifndef LINE_TRI_EN
  assign lt_act = 1'b0;
`endif

  // clock / reset
  always #5 clk_in = ~clk_in;

  // reference model: position is absolute time within the current frame
  int         ft = 0;
  logic       mm = 1'b0;
  logic [9:0] tm = '0;
  logic [9:0] mcnt = '0;

  task automatic model_step(input logic r, input logic e, input logic m, input logic [9:0] tl);
    int half, ns, vi, nbe, field_len, f, s, p, width;
    logic has, broad, hs, starts, lt;
    if (r || !e) begin
      ft = 0;
      mm = m;
      tm = tl;
      mcnt = '0;
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0});
    end else begin
      half = mm ? T_HALF_P : T_HALF_N;
      ns   = mm ? 625 : 525;
      vi   = mm ? 15 : 18;
      nbe  = mm ? 5 : 6;
      field_len = ns * half;
      f = ft / field_len;
      s = (ft % field_len) / half;
      p = ft % half;
      broad = (s >= nbe) && (s < 2 * nbe);
      if (s < vi) begin
        has = 1'b1;
        width = broad ? half - T_SER_W : T_EQ_W;
      end else begin
        has = (((s - vi) % 2) == f);
        width = T_HS_W;
      end
      hs = !(has && p < width);
      starts = has && p == 0;
      if (starts) mcnt = (ft == 0) ? 10'd1 : mcnt + 10'd1;
`ifdef LINE_TRI_EN
      lt = starts && tm != '0 && mcnt == tm;
`else
      lt = 1'b0;
`endif
      exp_q.push_back({hs, ft == 0, broad, f[0], mcnt, lt});
      ft++;
      if (ft == 2 * field_len) begin
        ft = 0;
        mm = m;
        tm = tl;
      end
    end
  endtask

  // driver: inputs change on the falling edge; the expected response is queued at once
  task automatic drive(input logic r, input logic e, input logic m, input logic [9:0] tl);
    @(negedge clk_in);
    rst = r;
    en = e;
    video_mode = m;
    tri_line = tl;
    model_step(r, e, m, tl);
  endtask

  function automatic logic [9:0] pick_tri();
    case ($urandom_range(0, 3))
      0: pick_tri = 10'd0;
      1: pick_tri = 10'd20;
      2: pick_tri = 10'd600;
      default: pick_tri = 10'($urandom_range(1, 700));
    endcase
  endfunction

  task automatic check_int(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // monitor / scoreboard
  int   cyc = 0;
  logic hs_prev = 1'b1;
  int   fall_cnt = 0;
  int   last_frame_falls = 0;

  always @(posedge clk_in) begin
    logic [14:0] exp_v;
    logic [14:0] act_v;
    logic        fell;
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {hs_out, odd_field_tri, vs_out, field_out, pulse_cnt, lt_act};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL outputs cyc=%0d got hs=%b odd=%b vs=%b fld=%b cnt=%0d lt=%b, expected hs=%b odd=%b vs=%b fld=%b cnt=%0d lt=%b",
                 cyc, act_v[14], act_v[13], act_v[12], act_v[11], act_v[10:1], act_v[0],
                 exp_v[14], exp_v[13], exp_v[12], exp_v[11], exp_v[10:1], exp_v[0]);
      end
    end
    fell = hs_prev && !hs_out;
    if (odd_field_tri === 1'b1) begin
      last_frame_falls = fall_cnt;
      fall_cnt = fell ? 1 : 0;
    end else if (fell === 1'b1) begin
      fall_cnt++;
    end
    hs_prev = hs_out;
  end

  initial begin
    logic       m;
    logic [9:0] tl;
    int         n;
    int         kind;

    // reset, NTSC
    repeat (3) drive(1'b1, 1'b1, 1'b0, 10'd20);

    // one full NTSC frame and the start of the next
    repeat (2 * 525 * T_HALF_N + 3) drive(1'b0, 1'b1, 1'b0, 10'd20);
    @(posedge clk_in);
    #2;
    check_int("ntsc_frame_falls", last_frame_falls, 543);

    // random mid-frame mode and trigger-line changes
    m = 1'b0;
    tl = 10'd20;
    for (int i = 0; i < 16000; i++) begin
      if ($urandom_range(0, 1999) == 0) m = ~m;
      if ($urandom_range(0, 4999) == 0) tl = pick_tri();
      drive(1'b0, 1'b1, m, tl);
    end

    // random aborts by reset, enable drop, or both
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(50, 1500);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 499) == 0) m = ~m;
        drive(1'b0, 1'b1, m, tl);
      end
      kind = $urandom_range(0, 2);
      m = 1'($urandom_range(0, 1));
      tl = pick_tri();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) drive(kind != 1, kind == 0, m, tl);
    end

    // full PAL frame from reset
    repeat (2) drive(1'b1, 1'b1, 1'b1, 10'd600);
    repeat (2 * 625 * T_HALF_P + 3) drive(1'b0, 1'b1, 1'b1, 10'd600);
    @(posedge clk_in);
    #2;
    check_int("pal_frame_falls", last_frame_falls, 640);

    // final report
    repeat (2) @(posedge clk_in);
    #2;
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
